decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/decode_fifo2.sv | 68 ++++++
 rtl/decode_ctrl.sv | 138 +++++++++++++
 tb/tb_decode_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate-select encodings and the field decoder.
// imm_sel encodings must match the immediate generator downstream.
package decode_pkg;

  localparam int unsigned XLen = 32;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [2:0] {
    ImmS     = 3'd0,
    ImmB     = 3'd1,
    ImmU     = 3'd2,
    ImmJ     = 3'd3,
    ImmI     = 3'd4,
    ImmIStar = 3'd5,
    ImmNone  = 3'd7
  } imm_sel_e;

  typedef struct packed {
    logic [XLen-1:0] inst;
    logic [XLen-1:0] pc;
  } fetch_t;

  typedef struct packed {
    imm_sel_e   imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_we;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode_inst(input logic [XLen-1:0] inst);
    dec_t d;
    logic no_wb;
    d.imm_sel = ImmNone;
    d.illegal = 1'b0;
    d.rs1     = inst[19:15];
    d.rs2     = inst[24:20];
    d.rd      = inst[11:7];
    no_wb     = 1'b0;
    case (inst[6:0])
      OpcLoad, OpcJalr, OpcSystem: d.imm_sel = ImmI;
      // Shift-immediates carry a shamt rather than a full 12-bit immediate.
      OpcOpImm: d.imm_sel = (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) ? ImmIStar : ImmI;
      OpcStore: begin
        d.imm_sel = ImmS;
        no_wb     = 1'b1;
      end
      OpcBranch: begin
        d.imm_sel = ImmB;
        no_wb     = 1'b1;
      end
      OpcLui, OpcAuipc: d.imm_sel = ImmU;
      OpcJal:           d.imm_sel = ImmJ;
      OpcOp:            d.imm_sel = ImmNone;
      default: begin
        d.imm_sel = ImmNone;
        d.illegal = 1'b1;
      end
    endcase
    d.reg_we = !no_wb && !d.illegal && (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/decode_fifo2.sv
// Two-entry valid/ready FIFO with synchronous flush and occupancy output.
// Flush wins over a push in the same cycle.
module decode_fifo2 #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: 2-entry skid FIFO feeding a registered output stage of decoded fields.
// The FIFO is bypassed when empty so an accepted instruction appears one cycle later.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_inst,
  input  logic [31:0] f_pc,
  output logic        f_ready,
  input  logic        flush,
  input  logic        x_ready,
  output logic        x_valid,
  output logic [31:0] x_inst,
  output logic [31:0] x_pc,
  output logic [2:0]  x_imm_sel,
  output logic [4:0]  x_rs1,
  output logic [4:0]  x_rs2,
  output logic [4:0]  x_rd,
  output logic        x_reg_we,
  output logic        x_illegal,
  output logic [31:0] stall_cnt
);

  fetch_t     f_in, fifo_head, src;
  logic       fifo_in_ready, fifo_out_valid, fifo_empty;
  logic [1:0] fifo_cnt;
  logic       out_load, bypass, load_valid;
  dec_t       dec;

  logic        x_valid_q, x_valid_d;
  logic [31:0] x_inst_q, x_inst_d;
  logic [31:0] x_pc_q, x_pc_d;
  imm_sel_e    x_imm_sel_q, x_imm_sel_d;
  logic [4:0]  x_rs1_q, x_rs1_d;
  logic [4:0]  x_rs2_q, x_rs2_d;
  logic [4:0]  x_rd_q, x_rd_d;
  logic        x_reg_we_q, x_reg_we_d;
  logic        x_illegal_q, x_illegal_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign f_in.inst = f_inst;
  assign f_in.pc   = f_pc;

  // f_ready depends only on FIFO occupancy, never on x_ready.
  assign f_ready    = fifo_in_ready;
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign out_load   = !x_valid_q || x_ready;
  assign bypass     = out_load && fifo_empty;
  assign load_valid = fifo_out_valid || f_valid;
  assign src        = fifo_out_valid ? fifo_head : f_in;
  assign dec        = decode_inst(src.inst);

  decode_fifo2 #(
    .Width($bits(fetch_t))
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (f_valid && !bypass),
    .in_ready_o (fifo_in_ready),
    .in_data_i  (f_in),
    .out_valid_o(fifo_out_valid),
    .out_ready_i(out_load),
    .out_data_o (fifo_head),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    x_valid_d   = x_valid_q;
    x_inst_d    = x_inst_q;
    x_pc_d      = x_pc_q;
    x_imm_sel_d = x_imm_sel_q;
    x_rs1_d     = x_rs1_q;
    x_rs2_d     = x_rs2_q;
    x_rd_d      = x_rd_q;
    x_reg_we_d  = x_reg_we_q;
    x_illegal_d = x_illegal_q;
    stall_cnt_d = stall_cnt_q;

    if (x_valid_q && !x_ready) stall_cnt_d = stall_cnt_q + 32'd1;

    if (flush) begin
      x_valid_d = 1'b0;
    end else if (out_load) begin
      x_valid_d = load_valid;
      if (load_valid) begin
        x_inst_d    = src.inst;
        x_pc_d      = src.pc;
        x_imm_sel_d = dec.imm_sel;
        x_rs1_d     = dec.rs1;
        x_rs2_d     = dec.rs2;
        x_rd_d      = dec.rd;
        x_reg_we_d  = dec.reg_we;
        x_illegal_d = dec.illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_valid_q   <= 1'b0;
      x_inst_q    <= '0;
      x_pc_q      <= '0;
      x_imm_sel_q <= ImmNone;
      x_rs1_q     <= '0;
      x_rs2_q     <= '0;
      x_rd_q      <= '0;
      x_reg_we_q  <= 1'b0;
      x_illegal_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_inst_q    <= x_inst_d;
      x_pc_q      <= x_pc_d;
      x_imm_sel_q <= x_imm_sel_d;
      x_rs1_q     <= x_rs1_d;
      x_rs2_q     <= x_rs2_d;
      x_rd_q      <= x_rd_d;
      x_reg_we_q  <= x_reg_we_d;
      x_illegal_q <= x_illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign x_valid   = x_valid_q;
  assign x_inst    = x_inst_q;
  assign x_pc      = x_pc_q;
  assign x_imm_sel = x_imm_sel_q;
  assign x_rs1     = x_rs1_q;
  assign x_rs2     = x_rs2_q;
  assign x_rd      = x_rd_q;
  assign x_reg_we  = x_reg_we_q;
  assign x_illegal = x_illegal_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios plus randomized traffic
// compared against an in-flight-queue model of the decode stage.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_inst = '0;
  logic [31:0] f_pc = '0;
  logic        f_ready;
  logic        flush = 1'b0;
  logic        x_ready = 1'b0;
  logic        x_valid;
  logic [31:0] x_inst, x_pc;
  logic [2:0]  x_imm_sel;
  logic [4:0]  x_rs1, x_rs2, x_rd;
  logic        x_reg_we, x_illegal;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every instruction held by the stage (output slot first), in order.
  logic [63:0] mq[$];
  logic [31:0] m_stall = '0;

  decode_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_valid  (f_valid),
    .f_inst   (f_inst),
    .f_pc     (f_pc),
    .f_ready  (f_ready),
    .flush    (flush),
    .x_ready  (x_ready),
    .x_valid  (x_valid),
    .x_inst   (x_inst),
    .x_pc     (x_pc),
    .x_imm_sel(x_imm_sel),
    .x_rs1    (x_rs1),
    .x_rs2    (x_rs2),
    .x_rd     (x_rd),
    .x_reg_we (x_reg_we),
    .x_illegal(x_illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // Reference decode straight from the opcode table.
  task automatic ref_decode(input logic [31:0] inst, output logic [2:0] imm,
                            output logic ill, output logic we);
    logic nowb;
    ill  = 1'b0;
    nowb = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: imm = 3'd4;
      7'b0010011: imm = (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) ? 3'd5 : 3'd4;
      7'b0100011: begin imm = 3'd0; nowb = 1'b1; end
      7'b1100011: begin imm = 3'd1; nowb = 1'b1; end
      7'b0110111, 7'b0010111: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110011: imm = 3'd7;
      default: begin imm = 3'd7; ill = 1'b1; end
    endcase
    we = !nowb && !ill && (inst[11:7] != 5'd0);
  endtask

  task automatic model_edge();
    int sz;
    if (!rst_n) begin
      mq.delete();
      m_stall = '0;
    end else begin
      sz = mq.size();
      if (sz > 0 && !x_ready) m_stall = m_stall + 32'd1;
      if (sz > 0 && x_ready) void'(mq.pop_front());
      if (f_valid && sz < 3) mq.push_back({f_pc, f_inst});
      if (flush) mq.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  opc [12];
    opc = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000, 7'b1111111};
    r = $urandom();
    if ($urandom_range(0, 4) == 0) return r;
    return {r[31:7], opc[$urandom_range(0, 11)]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; f_valid = 1'b1; f_inst = 32'h00500093; x_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({x_valid, x_illegal, x_reg_we} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b required 000", {x_valid, x_illegal, x_reg_we});
    end
    n_checks++;
    if ({x_inst, x_pc} !== 64'd0) begin
      n_errors++; $display("FAIL reset_inst_pc got %h %h required 0 0", x_inst, x_pc);
    end
    n_checks++;
    if (x_imm_sel !== 3'd7) begin
      n_errors++; $display("FAIL reset_imm_sel got %0d required 7", x_imm_sel);
    end
    n_checks++;
    if ({x_rs1, x_rs2, x_rd} !== 15'd0) begin
      n_errors++; $display("FAIL reset_regs got %h required 0", {x_rs1, x_rs2, x_rd});
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_stall got %0d required 0", stall_cnt);
    end
    rst_n = 1'b1; f_valid = 1'b0;
    n_checks++;
    if (f_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_f_ready got %b required 1", f_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst;
    x_ready = 1'b1; f_valid = 1'b1; f_inst = 32'h00500093; f_pc = 32'h0;
    tick();
    n_checks++;
    if ({x_valid, x_imm_sel, x_rd, x_reg_we} !== {1'b1, 3'd4, 5'd1, 1'b1}) begin
      n_errors++;
      $display("FAIL b2b_addi got v=%b imm=%0d rd=%0d we=%b required v=1 imm=4 rd=1 we=1",
               x_valid, x_imm_sel, x_rd, x_reg_we);
    end
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_errors++; $display("FAIL b2b_stall got %0d required 0", stall_cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      inst = 32'h00000093 | (32'(k) << 20) | (32'(k) << 7);
      f_inst = inst; f_pc = 32'(4 * k);
      tick();
      n_checks++;
      if ({x_valid, x_inst, x_pc, f_ready} !== {1'b1, inst, 32'(4 * k), 1'b1}) begin
        n_errors++;
        $display("FAIL b2b_stream k=%0d got v=%b inst=%h pc=%h rdy=%b required v=1 inst=%h pc=%h",
                 k, x_valid, x_inst, x_pc, f_ready, inst, 32'(4 * k));
      end
    end
    f_valid = 1'b0;
    tick();
    n_checks++;
    if (x_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_drain got %b required 0", x_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    logic [31:0] base;
    base = m_stall;
    for (int k = 0; k < 3; k++) ins[k] = 32'h00100113 + (32'(k) << 20);
    x_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_valid = 1'b1; f_inst = ins[k]; f_pc = 32'h100 + 32'(4 * k);
      tick();
    end
    n_checks++;
    if ({f_ready, x_valid, x_inst} !== {1'b0, 1'b1, ins[0]}) begin
      n_errors++; $display("FAIL bp_full got rdy=%b v=%b inst=%h required rdy=0 v=1 inst=%h",
                           f_ready, x_valid, x_inst, ins[0]);
    end
    n_checks++;
    if (stall_cnt !== base + 32'd2) begin
      n_errors++; $display("FAIL bp_stall_fill got %0d required %0d", stall_cnt, base + 32'd2);
    end
    f_inst = 32'hFFFF_FFFF; f_pc = 32'hBAD0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if ({x_valid, x_inst, x_pc, x_rd, stall_cnt} !==
          {1'b1, ins[0], 32'h100, 5'd2, base + 32'd2 + 32'(c)}) begin
        n_errors++;
        $display("FAIL bp_hold c=%0d got inst=%h pc=%h cnt=%0d required inst=%h pc=100 cnt=%0d",
                 c, x_inst, x_pc, stall_cnt, ins[0], base + 32'd2 + 32'(c));
      end
    end
    x_ready = 1'b1; f_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      tick();
      n_checks++;
      if ({x_valid, x_inst, x_pc} !== {1'b1, ins[k], 32'h100 + 32'(4 * k)}) begin
        n_errors++; $display("FAIL bp_order k=%0d got inst=%h pc=%h required inst=%h",
                             k, x_inst, x_pc, ins[k]);
      end
    end
    tick();
    n_checks++;
    if ({x_valid, f_ready, stall_cnt} !== {1'b0, 1'b1, base + 32'd5}) begin
      n_errors++; $display("FAIL bp_end got v=%b rdy=%b cnt=%0d required v=0 rdy=1 cnt=%0d",
                           x_valid, f_ready, stall_cnt, base + 32'd5);
    end
  endtask

  task automatic test_decode_sweep();
    logic [31:0] t_inst [7];
    logic [2:0]  t_imm  [7];
    logic        t_we   [7];
    logic        t_ill  [7];
    t_inst = '{32'h00209093, 32'h00112023, 32'h00000063, 32'h000010B7,
               32'h008000EF, 32'h002081B3, 32'h00000080};
    t_imm  = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd7};
    t_we   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    x_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      f_valid = 1'b1; f_inst = t_inst[k]; f_pc = 32'h200 + 32'(4 * k);
      tick();
      n_checks++;
      if ({x_valid, x_imm_sel, x_reg_we, x_illegal} !== {1'b1, t_imm[k], t_we[k], t_ill[k]}) begin
        n_errors++;
        $display("FAIL sweep_%h got imm=%0d we=%b ill=%b required imm=%0d we=%b ill=%b",
                 t_inst[k], x_imm_sel, x_reg_we, x_illegal, t_imm[k], t_we[k], t_ill[k]);
      end
      n_checks++;
      if ({x_rs1, x_rs2, x_rd} !== {t_inst[k][19:15], t_inst[k][24:20], t_inst[k][11:7]}) begin
        n_errors++; $display("FAIL sweep_regs_%h got %h required %h", t_inst[k],
                             {x_rs1, x_rs2, x_rd},
                             {t_inst[k][19:15], t_inst[k][24:20], t_inst[k][11:7]});
      end
    end
    f_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    x_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_valid = 1'b1; f_inst = 32'h00300193 + (32'(k) << 20); f_pc = 32'h300 + 32'(4 * k);
      tick();
    end
    flush = 1'b1; f_inst = 32'hDEAD_0093; f_pc = 32'hDEAD;
    tick();
    n_checks++;
    if ({x_valid, f_ready} !== 2'b01) begin
      n_errors++; $display("FAIL flush_now got v=%b rdy=%b required v=0 rdy=1", x_valid, f_ready);
    end
    n_checks++;
    if (stall_cnt !== m_stall) begin
      n_errors++; $display("FAIL flush_stall got %0d required %0d", stall_cnt, m_stall);
    end
    flush = 1'b0; f_valid = 1'b0; x_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (x_valid !== 1'b0) begin
        n_errors++; $display("FAIL flush_leak c=%0d got v=%b inst=%h required v=0",
                             c, x_valid, x_inst);
      end
    end
    f_valid = 1'b1; f_inst = 32'h00700393; f_pc = 32'h400;
    tick();
    f_valid = 1'b0;
    n_checks++;
    if ({x_valid, x_inst, x_pc} !== {1'b1, 32'h00700393, 32'h400}) begin
      n_errors++; $display("FAIL flush_resume got v=%b inst=%h required v=1 inst=00700393",
                           x_valid, x_inst);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    x_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_valid = 1'b1; f_inst = 32'h00500513 + (32'(k) << 20); f_pc = 32'h500 + 32'(4 * k);
      tick();
    end
    f_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if ({stall_cnt, f_ready} !== {32'd5, 1'b0}) begin
      n_errors++; $display("FAIL rst_mid_pre got cnt=%0d rdy=%b required cnt=5 rdy=0",
                           stall_cnt, f_ready);
    end
    rst_n = 1'b0; f_valid = 1'b1;
    tick();
    n_checks++;
    if ({x_valid, x_illegal, x_reg_we, stall_cnt, x_inst, x_pc, x_imm_sel, x_rs1, x_rs2, x_rd}
        !== {3'b000, 32'd0, 32'd0, 32'd0, 3'd7, 15'd0}) begin
      n_errors++;
      $display("FAIL rst_mid_out got v=%b cnt=%0d inst=%h pc=%h imm=%0d required all reset values",
               x_valid, stall_cnt, x_inst, x_pc, x_imm_sel);
    end
    rst_n = 1'b1; f_valid = 1'b0; x_ready = 1'b1;
    n_checks++;
    if (f_ready !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_ready got %b required 1", f_ready);
    end
    tick();
    n_checks++;
    if (x_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_drop got v=%b inst=%h required v=0", x_valid, x_inst);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_inst, e_pc;
    logic [2:0]  e_imm;
    logic        e_ill, e_we;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      f_valid = ($urandom_range(0, 9) < 7);
      x_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 31) == 0);
      f_inst  = gen_inst();
      f_pc    = $urandom();
      tick();
      n_checks++;
      if ({x_valid, f_ready} !== {mq.size() > 0, mq.size() < 3}) begin
        n_errors++; $display("FAIL rnd_ctrl c=%0d got v=%b rdy=%b required v=%b rdy=%b",
                             c, x_valid, f_ready, mq.size() > 0, mq.size() < 3);
      end
      n_checks++;
      if (stall_cnt !== m_stall) begin
        n_errors++; $display("FAIL rnd_stall c=%0d got %0d required %0d", c, stall_cnt, m_stall);
      end
      if (mq.size() > 0) begin
        {e_pc, e_inst} = mq[0];
        ref_decode(e_inst, e_imm, e_ill, e_we);
        n_checks++;
        if ({x_inst, x_pc} !== {e_inst, e_pc}) begin
          n_errors++; $display("FAIL rnd_data c=%0d got %h/%h required %h/%h",
                               c, x_inst, x_pc, e_inst, e_pc);
        end
        n_checks++;
        if ({x_imm_sel, x_illegal, x_reg_we, x_rs1, x_rs2, x_rd} !==
            {e_imm, e_ill, e_we, e_inst[19:15], e_inst[24:20], e_inst[11:7]}) begin
          n_errors++;
          $display("FAIL rnd_dec c=%0d inst=%h got imm=%0d ill=%b we=%b required imm=%0d ill=%b we=%b",
                   c, e_inst, x_imm_sel, x_illegal, x_reg_we, e_imm, e_ill, e_we);
        end
      end
    end
    flush = 1'b0; f_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_decode_sweep();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
